// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM:
// state codes, opcode/funct values, ALU operations and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REGA  = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ADDIU, OP_SLTI,
                      OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  // Jumps and unsupported opcodes complete in ID and never reach EX.
  function automatic logic ends_in_id(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_J) || (op == OP_JAL) ||
           ((op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR))) ||
           !op_supported(op);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from the current state and instruction fields.
module mc_output_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtOp,
  output logic [1:0] PCSource
);

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALUOUT;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REGB;
    ALUOp    = ALU_ADD;
    ExtOp    = 1'b0;
    PCSource = PCSRC_ALU;

    case (state)
      S_IF: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
      end

      S_ID: begin
        // ALU precomputes PC+4 + (imm<<2) so beq can use ALUOut in EX.
        ALUSrcB = SRCB_IMM_SH2;
        ExtOp   = 1'b1;
        if (OpCode == OP_J || OpCode == OP_JAL) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (OpCode == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = M2R_PC;
          end
        end else if (OpCode == OP_RTYPE && (Funct == FN_JR || Funct == FN_JALR)) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_REGA;
          if (Funct == FN_JALR) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RD;
            MemtoReg = M2R_PC;
          end
        end
      end

      S_EX: begin
        case (OpCode)
          OP_BEQ: begin
            ALUSrcA  = SRCA_REGA;
            ALUOp    = ALU_SUB;
            PCSource = PCSRC_ALUOUT;
            PCWrite  = Zero;
          end
          OP_LW, OP_SW, OP_ADDI, OP_ADDIU: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ExtOp   = 1'b1;
          end
          OP_SLTI, OP_SLTIU: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ExtOp   = 1'b1;
            ALUOp   = (OpCode == OP_SLTI) ? ALU_SLT : ALU_SLTU;
          end
          OP_ANDI, OP_ORI: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ALUOp   = (OpCode == OP_ANDI) ? ALU_AND : ALU_OR;
          end
          OP_LUI: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALU_LUI;
          end
          OP_RTYPE: begin
            ALUOp   = ALU_FUNCT;
            ALUSrcA = (Funct inside {FN_SLL, FN_SRL, FN_SRA}) ? SRCA_SHAMT : SRCA_REGA;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        if (OpCode == OP_LW) begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end else if (OpCode == OP_SW) begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
      end

      S_WB: begin
        case (OpCode)
          OP_LW: begin
            RegWrite = 1'b1;
            MemtoReg = M2R_MDR;
          end
          OP_RTYPE: begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RD;
          end
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: RegWrite = 1'b1;
          default: ;
        endcase
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: state register, next-state logic and reset gating of the control word.
//   state | meaning
//   IF  0 | fetch instruction, PC <= PC+4
//   ID  1 | decode, branch target precompute, jumps complete
//   EX  2 | ALU operation / branch resolve
//   MEM 3 | data memory access (lw/sw)
//   WB  4 | register-file write-back
//   5-7   | illegal, recover to IF
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtOp,
  output logic [1:0] PCSource,
  output logic [2:0] State
);

  logic [2:0] state_q, state_d;

  logic       dec_pcwrite, dec_iord, dec_memread, dec_memwrite, dec_irwrite, dec_regwrite;
  logic       dec_extop;
  logic [1:0] dec_regdst, dec_memtoreg, dec_alusrca, dec_alusrcb, dec_pcsource;
  logic [2:0] dec_aluop;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = ends_in_id(OpCode, Funct) ? S_IF : S_EX;
      S_EX: begin
        if (OpCode == OP_BEQ)                         state_d = S_IF;
        else if (OpCode == OP_LW || OpCode == OP_SW) state_d = S_MEM;
        else                                          state_d = S_WB;
      end
      S_MEM:   state_d = (OpCode == OP_LW) ? S_WB : S_IF;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  mc_output_decode u_decode (
    .state    (state_q),
    .OpCode   (OpCode),
    .Funct    (Funct),
    .Zero     (Zero),
    .PCWrite  (dec_pcwrite),
    .IorD     (dec_iord),
    .MemRead  (dec_memread),
    .MemWrite (dec_memwrite),
    .IRWrite  (dec_irwrite),
    .RegWrite (dec_regwrite),
    .RegDst   (dec_regdst),
    .MemtoReg (dec_memtoreg),
    .ALUSrcA  (dec_alusrca),
    .ALUSrcB  (dec_alusrcb),
    .ALUOp    (dec_aluop),
    .ExtOp    (dec_extop),
    .PCSource (dec_pcsource)
  );

  // The whole control word is held at zero while reset is high so no strobe can fire.
  assign PCWrite  = reset ? 1'b0   : dec_pcwrite;
  assign IorD     = reset ? 1'b0   : dec_iord;
  assign MemRead  = reset ? 1'b0   : dec_memread;
  assign MemWrite = reset ? 1'b0   : dec_memwrite;
  assign IRWrite  = reset ? 1'b0   : dec_irwrite;
  assign RegWrite = reset ? 1'b0   : dec_regwrite;
  assign RegDst   = reset ? 2'b00  : dec_regdst;
  assign MemtoReg = reset ? 2'b00  : dec_memtoreg;
  assign ALUSrcA  = reset ? 2'b00  : dec_alusrca;
  assign ALUSrcB  = reset ? 2'b00  : dec_alusrcb;
  assign ALUOp    = reset ? 3'b000 : dec_aluop;
  assign ExtOp    = reset ? 1'b0   : dec_extop;
  assign PCSource = reset ? 2'b00  : dec_pcsource;
  assign State    = reset ? S_IF   : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-instruction model queues the expected
// control word of every cycle, and each DUT cycle is popped and compared.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OpCode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALUOp, State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp),
    .PCSource(PCSource), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, rw;
    logic [1:0] rd, m2r, sa, sb;
    logic [2:0] aop;
    logic       ext;
    logic [1:0] pcs;
    logic [2:0] st;
  } ctl_t;

  ctl_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  function automatic ctl_t sample();
    ctl_t o;
    o.pcw = PCWrite;  o.iord = IorD;     o.mr = MemRead;  o.mw = MemWrite;
    o.irw = IRWrite;  o.rw = RegWrite;   o.rd = RegDst;   o.m2r = MemtoReg;
    o.sa = ALUSrcA;   o.sb = ALUSrcB;    o.aop = ALUOp;   o.ext = ExtOp;
    o.pcs = PCSource; o.st = State;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected control words for one whole instruction, starting at its fetch cycle.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ctl_t c;
    logic supported, is_r, shift, itype;
    supported = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a,
                           6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    is_r  = (op == 6'h00);
    shift = is_r && (fn inside {6'h00, 6'h02, 6'h03});
    itype = op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f};

    c = '0; c.st = 3'd0; c.pcw = 1; c.mr = 1; c.irw = 1; c.sb = 2'b01;
    q.push_back(c);

    c = '0; c.st = 3'd1; c.sb = 2'b11; c.ext = 1;
    if (op == 6'h02 || op == 6'h03) begin
      c.pcw = 1; c.pcs = 2'b10;
      if (op == 6'h03) begin c.rw = 1; c.rd = 2'b10; c.m2r = 2'b10; end
      q.push_back(c);
      return;
    end
    if (is_r && (fn == 6'h08 || fn == 6'h09)) begin
      c.pcw = 1; c.pcs = 2'b11;
      if (fn == 6'h09) begin c.rw = 1; c.rd = 2'b01; c.m2r = 2'b10; end
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (!supported) return;

    c = '0; c.st = 3'd2;
    if (op == 6'h04) begin
      c.sa = 2'b01; c.sb = 2'b00; c.aop = 3'b001; c.pcs = 2'b01; c.pcw = z;
      q.push_back(c);
      return;
    end
    if (is_r) begin
      c.sb = 2'b00; c.aop = 3'b010; c.sa = shift ? 2'b10 : 2'b01;
    end else if (op == 6'h0f) begin
      c.sb = 2'b10; c.aop = 3'b111;
    end else begin
      c.sa = 2'b01; c.sb = 2'b10;
      c.ext = !(op == 6'h0c || op == 6'h0d);
      case (op)
        6'h0a:   c.aop = 3'b101;
        6'h0b:   c.aop = 3'b110;
        6'h0c:   c.aop = 3'b011;
        6'h0d:   c.aop = 3'b100;
        default: c.aop = 3'b000;
      endcase
    end
    q.push_back(c);

    if (op == 6'h23 || op == 6'h2b) begin
      c = '0; c.st = 3'd3; c.iord = 1;
      if (op == 6'h23) c.mr = 1; else c.mw = 1;
      q.push_back(c);
      if (op == 6'h2b) return;
    end

    c = '0; c.st = 3'd4; c.rw = 1;
    if (op == 6'h23) c.m2r = 2'b01;
    if (is_r)        c.rd  = 2'b01;
    if (!(is_r || itype || op == 6'h23)) c.rw = 0;
    q.push_back(c);
  endtask

  // Inputs change #1 after posedge; outputs are sampled at negedge.
  task automatic step_cycle(input string tag);
    ctl_t e, o;
    @(negedge clk);
    e = q.pop_front();
    o = sample();
    check(tag, 32'(o), 32'(e));
    check({tag, "_mem_excl"}, 32'(o.mr & o.mw), 32'd0);
    check({tag, "_rw_mw"}, 32'(o.rw & o.mw), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int latency);
    OpCode = op; Funct = fn; Zero = z;
    push_instr(op, fn, z);
    check({tag, "_latency"}, 32'(q.size()), 32'(latency));
    while (q.size() > 0) step_cycle(tag);
    check({tag, "_back_to_if"}, 32'(State), 32'd0);
  endtask

  initial begin
    ctl_t o;
    #2;
    o = sample();
    check("reset_hold", 32'(o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addi abandoned by reset in its EX cycle
    OpCode = 6'h08; Funct = 6'h00; Zero = 1'b1;
    push_instr(6'h08, 6'h00, 1'b1);
    step_cycle("addi_pre");
    step_cycle("addi_pre");
    @(negedge clk);
    check("addi_in_ex", 32'(State), 32'd2);
    reset = 1'b1;
    #1;
    o = sample();
    check("reset_mid_ex", 32'(o), 32'd0);
    q.delete();
    @(posedge clk); #1;
    o = sample();
    check("reset_after_edge", 32'(o), 32'd0);
    reset = 1'b0;
    #1;
    check("fetch_strobes", 32'({PCWrite, IRWrite, MemRead, State}), 32'({3'b111, 3'd0}));

    run_instr("lw",       6'h23, 6'h00, 1'b0, 5);
    run_instr("beq_t",    6'h04, 6'h00, 1'b1, 3);
    run_instr("beq_nt",   6'h04, 6'h00, 1'b0, 3);
    run_instr("jal",      6'h03, 6'h00, 1'b0, 2);
    run_instr("jr",       6'h00, 6'h08, 1'b0, 2);
    run_instr("jalr",     6'h00, 6'h09, 1'b1, 2);
    run_instr("j",        6'h02, 6'h00, 1'b0, 2);
    run_instr("sll",      6'h00, 6'h00, 1'b0, 4);
    run_instr("sra",      6'h00, 6'h03, 1'b0, 4);
    run_instr("add",      6'h00, 6'h20, 1'b1, 4);
    run_instr("unsup",    6'h3f, 6'h00, 1'b0, 2);
    run_instr("bne_unsup",6'h05, 6'h00, 1'b1, 2);
    run_instr("sw",       6'h2b, 6'h00, 1'b0, 4);
    run_instr("addi",     6'h08, 6'h00, 1'b1, 4);
    run_instr("addiu",    6'h09, 6'h00, 1'b0, 4);
    run_instr("slti",     6'h0a, 6'h00, 1'b0, 4);
    run_instr("sltiu",    6'h0b, 6'h00, 1'b0, 4);
    run_instr("andi",     6'h0c, 6'h00, 1'b1, 4);
    run_instr("ori",      6'h0d, 6'h00, 1'b0, 4);
    run_instr("lui",      6'h0f, 6'h00, 1'b0, 4);
    run_instr("lw2",      6'h23, 6'h00, 1'b1, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
